cva6v_rvfi_retire_serializer: RTL and testbench
===============================================

# cva6v_rvfi_retire_serializer

Downstream consumer of the RVFI packer output. Takes up to `NrCommitPorts` retirement records per cycle, compacts the valid ones in port order, and buffers them in a FIFO. It presents them as a single in-order valid/ready stream, tagged with a 64-bit retire sequence number, to the tracer and scoreboard. Commit never stalls, so the block drops records on overflow and reports each drop.

## Interface
- `CVA6Cfg`, `cva6v_config_pkg::cva6_cfg_empty`: core config; provides `NrCommitPorts`.
- `rvfi_instr_t`, `logic`: per-port record type; block reads only its `valid` field and otherwise treats the record as opaque.
- `Depth`, 16: FIFO entries; must be a power of 2 and at least `NrCommitPorts`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset: synchronous, active-high.
- `rvfi_instr_i`  in  `NrCommitPorts` x `$bits(rvfi_instr_t)`  retirement records; a record is valid when its `.valid` is set.
- `flush_i`  in  1  discard FIFO contents; sequence counter is kept.
- `trace_valid_o`  out  1  head entry available.
- `trace_ready_i`  in  1  consumer accepts head.
- `trace_instr_o`  out  `$bits(rvfi_instr_t)`  head record.
- `trace_seq_o`  out  64  sequence number of head record.
- `overflow_o`  out  1  sticky; set on the first dropped record.
- `dropped_cnt_o`  out  32  count of dropped records (see Configuration).

## Operation
- Let `n` = number of valid input records in a cycle (0..`NrCommitPorts`).
- Compaction: valid records are written to consecutive FIFO slots in ascending port index; gaps between valid ports are removed.
- Sequence counter `seq_q` (64 bit):
  - every valid input record, accepted or dropped, receives `seq_q + k`, where `k` is its rank among that cycle's valid records;
  - `seq_q` then advances by `n`;
  - a consumer therefore detects drops as gaps in `trace_seq_o`.
- Admission is all-or-nothing per cycle, against free space `Depth - count_q`:
  - a same-cycle pop is NOT credited;
  - if `n` is at most the free space, all `n` records are written;
  - otherwise all `n` are dropped, `overflow_o` is set, and the drop counter is incremented by `n`.
- Pop: when `trace_valid_o && trace_ready_i`, the read pointer advances.
- Pointers: `log2(Depth)+1` bits; wrap is natural.
  - empty when the pointers are equal;
  - full when the MSBs differ and the rest is equal;
  - `count_q` is derived from the pointers.
- `flush_i`:
  - write pointer is set to the read pointer, so the FIFO is empty next cycle;
  - a pop in the same cycle is ignored;
  - input records in the flush cycle are dropped without setting overflow, but still consume sequence numbers;
  - `overflow_o` and the drop counter are kept.
- `overflow_o` is cleared only by reset.

## Timing
- Reset values: `trace_valid_o`=0, `trace_instr_o`=0, `trace_seq_o`=0, `overflow_o`=0, `dropped_cnt_o`=0; pointers and `seq_q` are 0.
- A record sampled at edge N appears at the head no earlier than after edge N+1.
  - Latency is 1 cycle into an empty FIFO, with no combinational input-to-output path.
- Output is registered from FIFO storage; `trace_instr_o` and `trace_seq_o` hold stable while `trace_valid_o && !trace_ready_i`.
- Full throughput: `NrCommitPorts` records in per cycle, 1 out per cycle.
- Reset asserted mid-operation: all state returns to reset values at the next edge; in-flight records are lost and not counted.
- Simultaneous push and pop at full: the pop proceeds and the push is evaluated against the pre-pop count, so it is dropped if `n` > 0.

## Configuration
- `CVA6V_RVFI_SER_DROP_CNT_EN` defined:
  - `dropped_cnt_o` is a 32-bit counter, saturating at `32'hFFFF_FFFF`;
  - it adds the dropped `n` on an overflow cycle and is not reset by flush.
- Not defined:
  - the counter register is not built and `dropped_cnt_o` is tied to 0;
  - `overflow_o` behaviour is unchanged.

## Test plan
- NrCommitPorts=2, Depth=8, ready=1. Valid on port 1 only, then a cycle with both ports valid:
  - stream is port1 rec (seq 0), port0 rec (seq 1), port1 rec (seq 2);
  - first valid output is 1 cycle after the first input.
- ready=0, 4 cycles with both ports valid fill 8 entries. 5th cycle with one valid record:
  - that record is dropped; `overflow_o`=1; `dropped_cnt_o`=1 (0 if macro undefined);
  - after draining, sequence numbers are 0..7 and the next accepted record carries seq 9.
- count=7, both ports valid, no pop:
  - both records are dropped (all-or-nothing); drop count increments by 2.
- count=8, pop and one valid input in the same cycle:
  - input is dropped; count=7 next cycle.
- 5 entries buffered, `flush_i`=1 with port 0 valid:
  - `trace_valid_o`=0 next cycle; `overflow_o` unchanged;
  - the next record carries seq incremented past the flushed input's number.
- Reset asserted while 3 entries are held and ready=0:
  - after one edge, all outputs are 0; the next input gets seq 0.

Source files
------------

// File: rtl/cva6v_rvfi_retire_serializer.sv
// cva6v_rvfi_retire_serializer
// Compacts up to NrCommitPorts RVFI retirement records per cycle into a FIFO
// and replays them as one in-order valid/ready stream, each record tagged with
// a 64-bit retire sequence number. Commit cannot be stalled, so a cycle whose
// records do not all fit is dropped as a whole and reported.
// Optional feature macro: CVA6V_RVFI_SER_DROP_CNT_EN builds the saturating
// 32-bit drop counter; without it dropped_cnt_o is tied to 0.
// Records are opaque DATA_W-bit vectors; bit VALID_IDX holds the .valid field.
module cva6v_rvfi_retire_serializer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 16,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned VALID_IDX     = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrCommitPorts*DATA_W-1:0] rvfi_instr_i,
  input  logic                            flush_i,
  output logic                            trace_valid_o,
  input  logic                            trace_ready_i,
  output logic [DATA_W-1:0]               trace_instr_o,
  output logic [63:0]                     trace_seq_o,
  output logic                            overflow_o,
  output logic [31:0]                     dropped_cnt_o
);

  localparam int unsigned IDX_W = $clog2(Depth);
  localparam int unsigned PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]         wptr_q, rptr_q;
  logic [PTR_W-1:0]         count, free, n;
  logic [PTR_W-1:0]         rank [NrCommitPorts];
  logic [IDX_W-1:0]         widx [NrCommitPorts];
  logic [NrCommitPorts-1:0] in_vld;
  logic [63:0]              seq_q;
  logic                     empty, push, drop, pop;

  // Entry storage: data only, never reset; validity comes from the pointers.
  logic [DATA_W-1:0] instr_mem [Depth];
  logic [63:0]       seq_mem   [Depth];

`ifdef CVA6V_RVFI_SER_DROP_CNT_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [PTR_W-1:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'(b);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction
`endif

  // Rank each valid port among this cycle's valid ports; rank is its slot offset.
  always_comb begin
    n = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      in_vld[p] = rvfi_instr_i[p*DATA_W + VALID_IDX];
      rank[p]   = n;
      widx[p]   = wptr_q[IDX_W-1:0] + rank[p][IDX_W-1:0];
      n         = n + PTR_W'(in_vld[p]);
    end
  end

  // Admission is all-or-nothing against pre-pop free space; flush wins over both.
  always_comb begin
    count         = wptr_q - rptr_q;
    free          = PTR_W'(Depth) - count;
    empty         = (wptr_q == rptr_q);
    push          = !flush_i && (n != '0) && (n <= free);
    drop          = !flush_i && (n > free);
    trace_valid_o = !empty;
    pop           = trace_valid_o && trace_ready_i && !flush_i;
    trace_instr_o = empty ? '0 : instr_mem[rptr_q[IDX_W-1:0]];
    trace_seq_o   = empty ? '0 : seq_mem[rptr_q[IDX_W-1:0]];
  end

  // Write accepted records into consecutive slots with their sequence numbers.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (push && in_vld[p]) begin
        instr_mem[widx[p]] <= rvfi_instr_i[p*DATA_W +: DATA_W];
        seq_mem[widx[p]]   <= seq_q + 64'(rank[p]);
      end
    end
  end

  // Pointer, sequence and overflow control.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      seq_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      seq_q <= seq_q + 64'(n);
      if (flush_i) begin
        wptr_q <= rptr_q;
      end else if (push) begin
        wptr_q <= wptr_q + n;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

`ifdef CVA6V_RVFI_SER_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  // Saturating count of records lost to overflow; flush does not touch it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      drop_cnt_q <= sat_add32(drop_cnt_q, n);
    end
  end

  assign dropped_cnt_o = drop_cnt_q;
`else
  assign dropped_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cva6v_rvfi_retire_serializer.sv
// Testbench for cva6v_rvfi_retire_serializer: directed scenarios followed by
// random traffic, all checked every cycle against a queue-based model.
module tb_cva6v_rvfi_retire_serializer;

  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [NP*DW-1:0] rvfi_instr_i;
  logic             flush_i;
  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [DW-1:0]    trace_instr_o;
  logic [63:0]      trace_seq_o;
  logic             overflow_o;
  logic [31:0]      dropped_cnt_o;

  cva6v_rvfi_retire_serializer #(
    .NrCommitPorts(NP),
    .Depth        (DEPTH),
    .DATA_W       (DW),
    .VALID_IDX    (0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rvfi_instr_i (rvfi_instr_i),
    .flush_i      (flush_i),
    .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i),
    .trace_instr_o(trace_instr_o),
    .trace_seq_o  (trace_seq_o),
    .overflow_o   (overflow_o),
    .dropped_cnt_o(dropped_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rec;
    logic [63:0]   seq;
  } ent_t;

  ent_t            mq[$];
  longint unsigned m_seq;
  bit              m_ovf;
  longint unsigned m_drop;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] exp_drop;
    bit          ev;
    ev = (mq.size() != 0);
`ifdef CVA6V_RVFI_SER_DROP_CNT_EN
    exp_drop = (m_drop > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_drop;
`else
    exp_drop = 0;
`endif
    check_eq("valid", {63'd0, trace_valid_o}, {63'd0, ev});
    check_eq("instr", {32'd0, trace_instr_o}, ev ? {32'd0, mq[0].rec} : 64'd0);
    check_eq("seq", trace_seq_o, ev ? mq[0].seq : 64'd0);
    check_eq("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
    check_eq("dropped", {32'd0, dropped_cnt_o}, exp_drop);
  endtask

  // One clock: drive inputs at the falling edge, advance the model across the
  // rising edge, then compare at the next falling edge.
  task automatic step(input logic [1:0] v, input bit rdy, input bit fl, input bit rs);
    logic [DW-1:0] rec [NP];
    int            n, sz;
    bit            do_pop;
    for (int p = 0; p < NP; p++) rec[p] = {$urandom() % (1 << 30), 1'b0, v[p]};
    rvfi_instr_i  = {rec[1], rec[0]};
    trace_ready_i = rdy;
    flush_i       = fl;
    rst_i         = rs;
    if (rs) begin
      mq.delete();
      m_seq  = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      n      = int'(v[0]) + int'(v[1]);
      sz     = mq.size();
      do_pop = (sz > 0) && rdy && !fl;
      if (fl) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (n <= DEPTH - sz) begin
          int k = 0;
          for (int p = 0; p < NP; p++) begin
            if (v[p]) begin
              mq.push_back('{rec: rec[p], seq: m_seq + 64'(k)});
              k++;
            end
          end
        end else begin
          m_ovf  = 1;
          m_drop = m_drop + 64'(n);
        end
      end
      m_seq = m_seq + 64'(n);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    step(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_i         = 1'b1;
    rvfi_instr_i  = '0;
    flush_i       = 1'b0;
    trace_ready_i = 1'b0;
    mq.delete();
    m_seq = 0; m_ovf = 0; m_drop = 0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();

    // Port 1 only, then both ports: stream seq 0 (p1), 1 (p0), 2 (p1).
    step(2'b10, 1, 0, 0);
    check_eq("tp1_first_valid", {63'd0, trace_valid_o}, 64'd1);
    check_eq("tp1_first_seq", trace_seq_o, 64'd0);
    step(2'b11, 1, 0, 0);
    check_eq("tp1_second_seq", trace_seq_o, 64'd1);
    repeat (3) step(2'b00, 1, 0, 0);

    // Fill 8 with ready low, then one more record is dropped.
    do_reset();
    repeat (4) step(2'b11, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    check_eq("tp2_overflow", {63'd0, overflow_o}, 64'd1);
    repeat (8) step(2'b00, 1, 0, 0);
    step(2'b01, 1, 0, 0);
    check_eq("tp2_next_seq", trace_seq_o, 64'd9);
    step(2'b00, 1, 0, 0);

    // count=7, two records, no pop: both dropped.
    do_reset();
    repeat (4) step(2'b11, 0, 0, 0);
    step(2'b00, 1, 0, 0);
    step(2'b11, 0, 0, 0);
    check_eq("tp3_head_seq", trace_seq_o, 64'd1);

    // count=8 with pop and one input: input dropped, pop proceeds.
    do_reset();
    repeat (4) step(2'b11, 0, 0, 0);
    step(2'b01, 1, 0, 0);
    check_eq("tp4_head_seq", trace_seq_o, 64'd1);
    repeat (8) step(2'b00, 1, 0, 0);

    // Flush with 5 buffered; flushed input still consumes seq 5.
    do_reset();
    step(2'b11, 0, 0, 0);
    step(2'b11, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    step(2'b01, 0, 1, 0);
    check_eq("tp5_flush_empty", {63'd0, trace_valid_o}, 64'd0);
    step(2'b01, 1, 0, 0);
    check_eq("tp5_next_seq", trace_seq_o, 64'd6);
    step(2'b00, 1, 0, 0);

    // Reset while 3 entries are held.
    step(2'b11, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    step(2'b11, 0, 0, 1);
    check_eq("tp6_valid_after_rst", {63'd0, trace_valid_o}, 64'd0);
    step(2'b01, 0, 0, 0);
    check_eq("tp6_seq_after_rst", trace_seq_o, 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] v;
      bit         rdy, fl, rs;
      v   = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 63) == 0);
      rs  = ($urandom_range(0, 399) == 0);
      step(v, rdy, fl, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
